// File: rtl/decoder_fec_pck.sv
// rtl/decoder_fec_pck.sv - shared types and codeword geometry for the Hamming decoder (DECODER_FEC_SECDED_EN selects SECDED)
package decoder_fec_pck;

`ifdef DECODER_FEC_SECDED_EN
    localparam int CW_W = 8;
`else
    localparam int CW_W = 7;
`endif

    localparam int SYN_W  = 3;
    localparam int POS_D1 = 3;
    localparam int POS_D2 = 5;
    localparam int POS_D3 = 6;
    localparam int POS_D4 = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        DECODE  = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } dec_state_t;

    // Bit i-1 of h holds Hamming position i; s1 is the LSB.
    function automatic logic [SYN_W-1:0] syndrome(input logic [6:0] h);
        syndrome[0] = h[0] ^ h[2] ^ h[4] ^ h[6];
        syndrome[1] = h[1] ^ h[2] ^ h[5] ^ h[6];
        syndrome[2] = h[3] ^ h[4] ^ h[5] ^ h[6];
    endfunction

endpackage

// File: rtl/fec_hamming_correct.sv
// rtl/fec_hamming_correct.sv - combinational syndrome check and single-bit correction (DECODER_FEC_SECDED_EN adds overall parity)
module fec_hamming_correct
    import decoder_fec_pck::*;
(
    input  logic [CW_W-1:0] cw,
    output logic [3:0]      nibble,
    output logic            corrected,
    output logic            uncorrectable
);

    logic [SYN_W-1:0] syn;
    logic             fix_en;

    assign syn = syndrome(cw[6:0]);

`ifdef DECODER_FEC_SECDED_EN
    // Odd overall parity means one flipped bit; with s = 0 it was bit 7, which carries no data.
    assign fix_en        = ^cw;
    assign corrected     = fix_en;
    assign uncorrectable = !fix_en && (syn != '0);
`else
    assign fix_en        = (syn != '0);
    assign corrected     = fix_en;
    assign uncorrectable = 1'b0;
`endif

    assign nibble[0] = cw[POS_D1-1] ^ (fix_en && (syn == SYN_W'(POS_D1)));
    assign nibble[1] = cw[POS_D2-1] ^ (fix_en && (syn == SYN_W'(POS_D2)));
    assign nibble[2] = cw[POS_D3-1] ^ (fix_en && (syn == SYN_W'(POS_D3)));
    assign nibble[3] = cw[POS_D4-1] ^ (fix_en && (syn == SYN_W'(POS_D4)));

endmodule

// File: rtl/decoder_fec_hamming.sv
// rtl/decoder_fec_hamming.sv - frame-driven Hamming decoder packing nibble pairs into bytes (DECODER_FEC_SECDED_EN selects SECDED)
module decoder_fec_hamming
    import decoder_fec_pck::*;
#(
    parameter int FRAME_BYTES = 16,
    parameter int CNT_W       = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             req,
    output logic             ack,
    output logic             busy,
    input  logic             buff_empty,
    input  logic             buff_rd_valid,
    input  logic [CW_W-1:0]  buff_rd_data,
    output logic             rd_en_buff,
    input  logic             buff_full,
    output logic             wr_en_buff,
    output logic [7:0]       wr_data,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES);

    dec_state_t      state;
    logic [7:0]      byte_cnt;
    logic [7:0]      byte_nxt;
    logic            nib_sel;
    logic            cw_held;
    logic [CW_W-1:0] cw_reg;
    logic [3:0]      low_nib;
    logic [3:0]      nibble;
    logic            corrected;
    logic            uncorrectable;

    fec_hamming_correct u_correct (
        .cw            (cw_reg),
        .nibble        (nibble),
        .corrected     (corrected),
        .uncorrectable (uncorrectable)
    );

    assign byte_nxt   = byte_cnt + 8'd1;
    assign rd_en_buff = en && (state == RD_REQ) && !buff_empty;
    assign wr_en_buff = en && (state == WRITE) && !buff_full;
    assign ack        = (state == DONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            nib_sel    <= 1'b0;
            cw_held    <= 1'b0;
            cw_reg     <= '0;
            low_nib    <= '0;
            wr_data    <= '0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            // Returning read data is latched even with en low so a stall never drops a codeword.
            if (state == RD_WAIT && buff_rd_valid && !cw_held) begin
                cw_reg  <= buff_rd_data;
                cw_held <= 1'b1;
            end
            if (en) begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            byte_cnt   <= '0;
                            nib_sel    <= 1'b0;
                            corr_cnt   <= '0;
                            uncorr_cnt <= '0;
                            state      <= RD_REQ;
                        end
                    end
                    RD_REQ: begin
                        if (!buff_empty) state <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        if (cw_held || buff_rd_valid) state <= DECODE;
                    end
                    DECODE: begin
                        cw_held <= 1'b0;
                        if (corrected && corr_cnt != '1)
                            corr_cnt <= corr_cnt + CNT_W'(1);
                        if (uncorrectable && uncorr_cnt != '1)
                            uncorr_cnt <= uncorr_cnt + CNT_W'(1);
                        if (!nib_sel) begin
                            low_nib <= nibble;
                            nib_sel <= 1'b1;
                            state   <= RD_REQ;
                        end else begin
                            wr_data <= {nibble, low_nib};
                            state   <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (!buff_full) begin
                            byte_cnt <= byte_nxt;
                            if (byte_nxt == LAST_BYTE) begin
                                state <= DONE;
                            end else begin
                                nib_sel <= 1'b0;
                                state   <= RD_REQ;
                            end
                        end
                    end
                    DONE: begin
                        if (!req) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decoder_fec_hamming.sv
// tb/tb_decoder_fec_hamming.sv - randomized self-checking bench for decoder_fec_hamming (follows DECODER_FEC_SECDED_EN)
module tb_decoder_fec_hamming;
    import decoder_fec_pck::*;

    localparam int FB    = 16;
    localparam int CNT_W = 16;
`ifdef DECODER_FEC_SECDED_EN
    localparam int MAXE = 2;
`else
    localparam int MAXE = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            req = 1'b0;
    logic            buff_empty = 1'b1;
    logic            buff_rd_valid = 1'b0;
    logic [CW_W-1:0] buff_rd_data = '0;
    logic            buff_full = 1'b0;
    logic            ack, busy, rd_en_buff, wr_en_buff;
    logic [7:0]      wr_data;
    logic [CNT_W-1:0] corr_cnt, uncorr_cnt;

    always #5 clk = ~clk;

    decoder_fec_hamming #(.FRAME_BYTES(FB), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req           (req),
        .ack           (ack),
        .busy          (busy),
        .buff_empty    (buff_empty),
        .buff_rd_valid (buff_rd_valid),
        .buff_rd_data  (buff_rd_data),
        .rd_en_buff    (rd_en_buff),
        .buff_full     (buff_full),
        .wr_en_buff    (wr_en_buff),
        .wr_data       (wr_data),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [CW_W-1:0] in_q[$];
    logic [7:0]      out_q[$];
    logic [3:0]      exp_nib[$];
    int              exp_corr, exp_unc;
    bit              force_empty = 1'b0;
    int              lat = 1;
    bit              pend = 1'b0;
    int              pend_lat = 0;
    logic [CW_W-1:0] pend_data = '0;
    int              n_rd = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder built straight from the position rules.
    function automatic logic [CW_W-1:0] encode(input logic [3:0] d);
        logic [7:0] c;
        c    = '0;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[7] = ^c[6:0];
        return c[CW_W-1:0];
    endfunction

    function automatic logic [7:0] rand_mask(input int max_err);
        logic [7:0] m;
        int ne, b0, b1;
        m  = '0;
        ne = int'($urandom_range(0, max_err));
        b0 = int'($urandom_range(0, CW_W-1));
        b1 = (b0 + int'($urandom_range(1, CW_W-1))) % CW_W;
        if (ne >= 1) m[b0] = 1'b1;
        if (ne >= 2) m[b1] = 1'b1;
        return m;
    endfunction

    task automatic add_cw(input logic [3:0] d, input logic [7:0] mask);
        logic [CW_W-1:0] c;
        int ne;
        c  = encode(d) ^ mask[CW_W-1:0];
        ne = $countones(mask[CW_W-1:0]);
        in_q.push_back(c);
        if (ne == 2) begin
            exp_nib.push_back({c[6], c[5], c[4], c[2]});
            exp_unc++;
        end else begin
            exp_nib.push_back(d);
            if (ne == 1) exp_corr++;
        end
    endtask

    task automatic prep_frame();
        exp_nib.delete();
        out_q.delete();
        exp_corr = 0;
        exp_unc  = 0;
    endtask

    // Input buffer with configurable read latency, output buffer capture and strobe protocol checks.
    initial forever begin
        @(negedge clk);
        if (!rst_n) pend = 1'b0;
        buff_rd_valid = 1'b0;
        if (pend) begin
            if (pend_lat <= 1) begin
                buff_rd_valid = 1'b1;
                buff_rd_data  = pend_data;
                pend          = 1'b0;
            end else begin
                pend_lat--;
            end
        end
        buff_empty = force_empty || (in_q.size() == 0);
        #1;
        if (rst_n) begin
            if (rd_en_buff) begin
                check("rd_en_gated", en, 1);
                check("rd_not_empty", buff_empty, 0);
                check("rd_one_outstanding", pend, 0);
                pend     = 1'b1;
                pend_lat = lat;
                if (in_q.size() > 0) pend_data = in_q.pop_front();
                n_rd++;
            end
            if (wr_en_buff) begin
                check("wr_en_gated", en, 1);
                check("wr_not_full", buff_full, 0);
                out_q.push_back(wr_data);
            end
        end
    end

    task automatic run_frame(input string name, input int max_err, input bit bp,
                             input bit en_pulse, input bit early_drop);
        int  stall, en_left, rd0;
        bit  done;
        logic [7:0] expb;
        while (exp_nib.size() < 2*FB) add_cw(4'($urandom_range(0, 15)), rand_mask(max_err));
        lat     = bp ? 3 : 1;
        stall   = 0;
        en_left = -1;
        rd0     = n_rd;
        done    = 1'b0;
        @(negedge clk);
        req = 1'b1;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            if (bp) begin
                if (stall > 0) stall--;
                else if ($urandom_range(0, 3) == 0) stall = 5;
                buff_full   = (stall > 0);
                force_empty = ($urandom_range(0, 2) == 0);
            end
            if (en_pulse && en_left < 0 && n_rd >= rd0 + 3) en_left = 4;
            if (en_left > 0) begin
                en = 1'b0;
                en_left--;
            end else begin
                en = 1'b1;
            end
            if (early_drop && c == 20) req = 1'b0;
            #2;
            done = ack;
        end
        buff_full   = 1'b0;
        force_empty = 1'b0;
        en          = 1'b1;
        check({name, "_ack"}, ack, 1);
        check({name, "_nbytes"}, out_q.size(), FB);
        check({name, "_nreads"}, n_rd - rd0, 2*FB);
        for (int k = 0; k < FB && k < out_q.size(); k++) begin
            expb = {exp_nib[2*k+1], exp_nib[2*k]};
            check({name, "_byte"}, out_q[k], expb);
        end
        check({name, "_corr"}, corr_cnt, exp_corr);
        check({name, "_uncorr"}, uncorr_cnt, exp_unc);
        if (early_drop) begin
            @(negedge clk); #2;
            check({name, "_ack_drop"}, ack, 0);
            check({name, "_idle"}, busy, 0);
        end else begin
            for (int h = 0; h < 4; h++) begin
                @(negedge clk); #2;
                check({name, "_ack_hold"}, ack, 1);
                check({name, "_corr_stable"}, corr_cnt, exp_corr);
            end
            @(negedge clk);
            req = 1'b0;
            #2;
            check({name, "_ack_last"}, ack, 1);
            @(negedge clk); #2;
            check({name, "_ack_drop"}, ack, 0);
            check({name, "_idle"}, busy, 0);
        end
    endtask

    initial begin
        logic [31:0] first;
        int rd0;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en_buff, 0);
        check("rst_wr_en", wr_en_buff, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_corr", corr_cnt, 0);
        check("rst_uncorr", uncorr_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // Clean frame: 0x55 then 0x00 decodes to 0x0B
        prep_frame();
        add_cw(4'hB, 8'h00);
        add_cw(4'h0, 8'h00);
        run_frame("clean", 0, 1'b0, 1'b0, 1'b0);
        first = (out_q.size() > 0) ? 32'(out_q[0]) : 32'hxxxx_xxxx;
        check("clean_byte0", first, 32'h0B);
        check("clean_corr0", corr_cnt, 0);

        // Single error: 0x51 (bit 2 flipped) then 0x00
        prep_frame();
        add_cw(4'hB, 8'h04);
        add_cw(4'h0, 8'h00);
        run_frame("single", 1, 1'b0, 1'b0, 1'b0);
        first = (out_q.size() > 0) ? 32'(out_q[0]) : 32'hxxxx_xxxx;
        check("single_byte0", first, 32'h0B);

`ifdef DECODER_FEC_SECDED_EN
        // Double error: 0x56 passes through uncorrected
        prep_frame();
        add_cw(4'hB, 8'h03);
        add_cw(4'h0, 8'h00);
        run_frame("double", 0, 1'b0, 1'b0, 1'b0);
        first = (out_q.size() > 0) ? 32'(out_q[0]) : 32'hxxxx_xxxx;
        check("double_byte0", first, 32'h0B);
        check("double_uncorr", uncorr_cnt, 1);
        check("double_corr", corr_cnt, 0);
`endif

        // Back-pressure on both buffers with 3-cycle read latency
        prep_frame();
        run_frame("backpressure", MAXE, 1'b1, 1'b0, 1'b0);

        // Enable dropped for 4 cycles while a read is returning
        prep_frame();
        run_frame("enable", MAXE, 1'b0, 1'b1, 1'b0);

        // req released mid-frame: frame still completes, ack then drops
        prep_frame();
        run_frame("early_req", MAXE, 1'b0, 1'b0, 1'b1);

        // Reset after the first nibble aborts the frame
        prep_frame();
        while (exp_nib.size() < 2*FB) add_cw(4'($urandom_range(0, 15)), rand_mask(MAXE));
        rd0 = n_rd;
        @(negedge clk);
        req = 1'b1;
        for (int c = 0; c < 200 && n_rd < rd0 + 2; c++) begin
            @(negedge clk); #2;
        end
        check("abort_reads", n_rd - rd0, 2);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        check("abort_ack", ack, 0);
        check("abort_busy", busy, 0);
        check("abort_rd_en", rd_en_buff, 0);
        check("abort_wr_en", wr_en_buff, 0);
        check("abort_wr_data", wr_data, 0);
        check("abort_corr", corr_cnt, 0);
        check("abort_uncorr", uncorr_cnt, 0);
        in_q.delete();
        pend = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("abort_no_ack", ack, 0);

        prep_frame();
        run_frame("after_reset", MAXE, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
